top: RTL and testbench



---
 rtl/top.sv | 115 +++++++++++
 tb/tb_top.sv | 127 ++++++++++++
 2 files changed

// File: rtl/top.sv
// Single-cycle 8-bit CPU: built-in 32-word ROM, 4x8 register file, zero flag,
// 16-byte data memory. Runs its fixed program after reset and halts on HLT.
module top (
    input  logic clk,
    input  logic reset
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
    localparam logic [3:0] OP_ADDI = 4'hC;
    localparam logic [3:0] OP_HLT  = 4'hF;

    logic [4:0]  pc;
    logic [7:0]  rf   [0:3];
    logic        z;
    logic        halted;
    logic [7:0]  dmem [0:15];
    logic [15:0] rom  [0:31];

    function automatic logic [15:0] rom_word(input logic [4:0] a);
        case (a)
            5'd0:    rom_word = 16'h1005;
            5'd1:    rom_word = 16'h1403;
            5'd2:    rom_word = 16'h2100;
            5'd3:    rom_word = 16'h9000;
            5'd4:    rom_word = 16'h1803;
            5'd5:    rom_word = 16'hC8FF;
            5'd6:    rom_word = 16'hB008;
            5'd7:    rom_word = 16'hA005;
            5'd8:    rom_word = 16'h8C00;
            5'd9:    rom_word = 16'hF000;
            default: rom_word = 16'h0000;
        endcase
    endfunction

    for (genvar g = 0; g < 32; g++) begin : g_rom
        assign rom[g] = rom_word(5'(g));
    end

    logic [15:0] w_instr;
    logic [3:0]  w_op;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;
    logic [7:0]  w_imm;
    logic [7:0]  w_rd_val;
    logic [7:0]  w_rs_val;

    assign w_instr  = rom[pc];
    assign w_op     = w_instr[15:12];
    assign w_rd     = w_instr[11:10];
    assign w_rs     = w_instr[9:8];
    assign w_imm    = w_instr[7:0];
    assign w_rd_val = rf[w_rd];
    assign w_rs_val = rf[w_rs];

    logic [7:0] w_wdata;
    logic       w_rf_we;
    logic       w_z_we;
    logic       w_dm_we;
    logic       w_halt;
    logic [4:0] w_pc_next;

    always_comb begin
        w_wdata   = 8'h00;
        w_rf_we   = 1'b0;
        w_z_we    = 1'b0;
        w_dm_we   = 1'b0;
        w_halt    = 1'b0;
        w_pc_next = pc + 5'd1;
        case (w_op)
            OP_LDI:  begin w_wdata = w_imm;               w_rf_we = 1'b1; end
            OP_ADD:  begin w_wdata = w_rd_val + w_rs_val; w_rf_we = 1'b1; w_z_we = 1'b1; end
            OP_SUB:  begin w_wdata = w_rd_val - w_rs_val; w_rf_we = 1'b1; w_z_we = 1'b1; end
            OP_AND:  begin w_wdata = w_rd_val & w_rs_val; w_rf_we = 1'b1; w_z_we = 1'b1; end
            OP_OR:   begin w_wdata = w_rd_val | w_rs_val; w_rf_we = 1'b1; w_z_we = 1'b1; end
            OP_XOR:  begin w_wdata = w_rd_val ^ w_rs_val; w_rf_we = 1'b1; w_z_we = 1'b1; end
            OP_MOV:  begin w_wdata = w_rs_val;            w_rf_we = 1'b1; end
            OP_LD:   begin w_wdata = dmem[w_imm[3:0]];    w_rf_we = 1'b1; end
            OP_ST:   w_dm_we = 1'b1;
            OP_JMP:  w_pc_next = w_imm[4:0];
            OP_BZ:   if (z) w_pc_next = w_imm[4:0];
            OP_ADDI: begin w_wdata = w_rd_val + w_imm;    w_rf_we = 1'b1; w_z_we = 1'b1; end
            // HLT parks the pc on itself so the halted pc names the HLT
            OP_HLT:  begin w_halt = 1'b1; w_pc_next = pc; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= 5'd0;
            z      <= 1'b0;
            halted <= 1'b0;
            for (int i = 0; i < 4; i++)  rf[i]   <= 8'h00;
            for (int i = 0; i < 16; i++) dmem[i] <= 8'h00;
        end else if (!halted) begin
            pc <= w_pc_next;
            if (w_rf_we) rf[w_rd] <= w_wdata;
            if (w_z_we)  z <= (w_wdata == 8'h00);
            if (w_dm_we) dmem[w_imm[3:0]] <= w_rd_val;
            if (w_halt)  halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_top.sv
// Directed bench for the built-in program of top: reset, partial/full runs,
// loop branch, halt hold and asynchronous mid-loop reset.
module tb_top;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    top dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, " pc"}, 32'(dut.pc), 32'd0);
        check_val({tag, " z"}, 32'(dut.z), 32'd0);
        check_val({tag, " halted"}, 32'(dut.halted), 32'd0);
        for (int i = 0; i < 4; i++)
            check_val($sformatf("%s rf[%0d]", tag, i), 32'(dut.rf[i]), 32'd0);
        for (int i = 0; i < 16; i++)
            check_val($sformatf("%s dmem[%0d]", tag, i), 32'(dut.dmem[i]), 32'd0);
    endtask

    task automatic check_final(input string tag);
        check_val({tag, " r0"}, 32'(dut.rf[0]), 32'h08);
        check_val({tag, " r1"}, 32'(dut.rf[1]), 32'h03);
        check_val({tag, " r2"}, 32'(dut.rf[2]), 32'h00);
        check_val({tag, " r3"}, 32'(dut.rf[3]), 32'h08);
        check_val({tag, " dmem0"}, 32'(dut.dmem[0]), 32'h08);
        check_val({tag, " z"}, 32'(dut.z), 32'd1);
        check_val({tag, " halted"}, 32'(dut.halted), 32'd1);
        check_val({tag, " pc"}, 32'(dut.pc), 32'd9);
        for (int i = 1; i < 16; i++)
            check_val($sformatf("%s dmem[%0d]", tag, i), 32'(dut.dmem[i]), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        step(2);
        check_cleared("por");
        check_val("rom9", 32'(dut.rom[9]), 32'hF000);
        check_val("rom20", 32'(dut.rom[20]), 32'h0000);

        @(negedge clk);
        reset = 1'b0;

        // edges counted from reset release
        step(3);
        check_val("e3 r0", 32'(dut.rf[0]), 32'h08);
        check_val("e3 r1", 32'(dut.rf[1]), 32'h03);
        check_val("e3 z", 32'(dut.z), 32'd0);
        check_val("e3 pc", 32'(dut.pc), 32'd3);
        check_val("e3 dmem0", 32'(dut.dmem[0]), 32'h00);
        step(1);
        check_val("e4 dmem0", 32'(dut.dmem[0]), 32'h08);
        step(2);
        check_val("e6 r2", 32'(dut.rf[2]), 32'h02);
        check_val("e6 pc", 32'(dut.pc), 32'd6);
        step(1);
        check_val("e7 pc", 32'(dut.pc), 32'd7);
        step(1);
        check_val("e8 r2", 32'(dut.rf[2]), 32'h02);
        check_val("e8 z", 32'(dut.z), 32'd0);
        check_val("e8 pc", 32'(dut.pc), 32'd5);
        step(4);
        check_val("e12 r2", 32'(dut.rf[2]), 32'h00);
        check_val("e12 z", 32'(dut.z), 32'd1);
        check_val("e12 pc", 32'(dut.pc), 32'd6);
        step(1);
        check_val("e13 r2", 32'(dut.rf[2]), 32'h00);
        check_val("e13 z", 32'(dut.z), 32'd1);
        check_val("e13 pc", 32'(dut.pc), 32'd8);
        step(1);
        check_val("e14 r3", 32'(dut.rf[3]), 32'h08);
        check_val("e14 halted", 32'(dut.halted), 32'd0);
        step(1);
        check_final("e15");

        step(10);
        check_final("hold");

        // async reset while halted, between edges
        #3;
        reset = 1'b1;
        #1;
        check_cleared("halt rst");
        @(negedge clk);
        reset = 1'b0;

        step(6);
        check_val("rerun pc6", 32'(dut.pc), 32'd6);
        check_val("rerun r2", 32'(dut.rf[2]), 32'h02);
        #3;
        reset = 1'b1;
        #1;
        check_cleared("loop rst");
        @(negedge clk);
        check_cleared("loop rst held");
        reset = 1'b0;

        step(15);
        check_final("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
